// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared definitions for the core-to-Wishbone pipelined adapter
// Contents: core2wb_state_e (adapter state encoding) and WB_MAX_OUTSTANDING
// (upper bound on the number of in-flight transactions).
package wb_pkg;

  localparam int WB_MAX_OUTSTANDING = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ABORT = 2'd1,
    FLUSH = 2'd2
  } core2wb_state_e;

endpackage

// File: rtl/core2wb_tag_fifo.sv
// rtl/core2wb_tag_fifo.sv - in-order 1-bit tag queue for outstanding bus transactions
// Ports: clk, rst_n (async, active low); flush empties the queue; push/push_tag
// append one tag; pop removes the head; pop_tag shows the head; count is occupancy.
module core2wb_tag_fifo
  import wb_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       push_tag,
  input  logic                       pop,
  output logic                       pop_tag,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int CntWidth = $clog2(Depth + 1);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] Full    = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  if (Depth < 1 || Depth > WB_MAX_OUTSTANDING) begin : g_bad_depth
    $error("core2wb_tag_fifo: Depth out of range");
  end

  logic [Depth-1:0]    mem;
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [CntWidth-1:0] cnt_q;
  logic                do_push;
  logic                do_pop;

  // Pop on empty is dropped; push on full is accepted only if a pop frees a slot.
  assign do_pop  = pop & (cnt_q != '0);
  assign do_push = push & ((cnt_q != Full) | do_pop);

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_tag;
  end

  assign pop_tag = mem[rd_ptr];
  assign count   = cnt_q;

endmodule

// File: rtl/core2wb_pipe.sv
// rtl/core2wb_pipe.sv - pipelined OBI-style core port to Wishbone B4 pipelined master
// Core side: req/we/addr/be/wdata in, gnt (combinational), rvalid/rdata/err (registered).
// Bus side: wb_cyc/wb_stb/wb_we/wb_adr/wb_sel/wb_dat_o out, wb_stall/wb_ack/wb_err/wb_dat_i in.
// clk single clock, rst_n async active-low reset.
module core2wb_pipe
  import wb_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2,
  parameter int TimeoutCycles  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [AddrWidth-1:0]   addr,
  input  logic [DataWidth/8-1:0] be,
  input  logic [DataWidth-1:0]   wdata,
  output logic                   gnt,
  output logic                   rvalid,
  output logic [DataWidth-1:0]   rdata,
  output logic                   err,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [AddrWidth-1:0]   wb_adr,
  output logic [DataWidth/8-1:0] wb_sel,
  output logic [DataWidth-1:0]   wb_dat_o,
  input  logic                   wb_stall,
  input  logic                   wb_ack,
  input  logic                   wb_err,
  input  logic [DataWidth-1:0]   wb_dat_i
);

  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int WdWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
  localparam logic [WdWidth-1:0]  WdLimit = WdWidth'(TimeoutCycles);

  if (MaxOutstanding < 1 || MaxOutstanding > WB_MAX_OUTSTANDING) begin : g_bad_outstanding
    $error("core2wb_pipe: MaxOutstanding out of range");
  end
  if (DataWidth % 8 != 0) begin : g_bad_width
    $error("core2wb_pipe: DataWidth must be a multiple of 8");
  end

  core2wb_state_e       state_q, state_d;
  logic [CntWidth-1:0]  cnt;
  logic [CntWidth-1:0]  cnt_after;
  logic [WdWidth-1:0]   wd_q, wd_d;
  logic                 tag_is_write;
  logic                 stb_int, cyc_int, issue, pop;
  logic                 rsp_valid_d, rsp_err_d;
  logic [DataWidth-1:0] rsp_data_d;

  core2wb_tag_fifo #(.Depth(MaxOutstanding)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (1'b0),
    .push     (issue),
    .push_tag (we),
    .pop      (pop),
    .pop_tag  (tag_is_write),
    .count    (cnt)
  );

  always_comb begin
    state_d     = state_q;
    stb_int     = 1'b0;
    cyc_int     = 1'b0;
    issue       = 1'b0;
    pop         = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    cnt_after   = cnt;
    wd_d        = '0;
    case (state_q)
      RUN: begin
        // rst_n gating keeps the strobe quiet while reset is held with req high.
        stb_int     = rst_n & req & (cnt < MaxCnt);
        cyc_int     = stb_int | (cnt != '0);
        issue       = stb_int & ~wb_stall;
        pop         = (wb_ack | wb_err) & (cnt != '0);
        rsp_valid_d = pop;
        rsp_err_d   = pop & wb_err;
        rsp_data_d  = (pop && !tag_is_write && !wb_err) ? wb_dat_i : '0;
        cnt_after   = cnt + CntWidth'(issue) - CntWidth'(pop);
        // wd holds the number of cycles since the last issue or termination.
        if (cnt_after == '0)  wd_d = '0;
        else if (issue | pop) wd_d = WdWidth'(1);
        else                  wd_d = wd_q + WdWidth'(1);
        if (TimeoutCycles > 0 && cnt_after != '0 && wd_d >= WdLimit) state_d = ABORT;
      end
      ABORT, FLUSH: begin
        // The first error answer is popped already in ABORT so the k-th error
        // response lands k cycles after the abort cycle.
        pop         = (cnt != '0);
        rsp_valid_d = pop;
        rsp_err_d   = 1'b1;
        if (state_q == ABORT)        state_d = FLUSH;
        else if (cnt <= CntWidth'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wd_q    <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      rvalid  <= rsp_valid_d;
      err     <= rsp_err_d;
      rdata   <= rsp_data_d;
    end
  end

  assign gnt      = issue;
  assign wb_stb   = stb_int;
  assign wb_cyc   = cyc_int;
  assign wb_we    = we;
  assign wb_adr   = addr;
  assign wb_sel   = be;
  assign wb_dat_o = wdata;

endmodule

// File: tb/tb_core2wb_pipe.sv
// tb/tb_core2wb_pipe.sv - self-checking bench for core2wb_pipe
module tb_core2wb_pipe;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW/8-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic gnt, rvalid, err;
  logic [DW-1:0] rdata;
  logic wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW/8-1:0] wb_sel;
  logic [DW-1:0] wb_dat_o;
  logic wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;

  always #5 clk = ~clk;

  core2wb_pipe #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_stall(wb_stall), .wb_ack(wb_ack), .wb_err(wb_err), .wb_dat_i(wb_dat_i)
  );

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW/8-1:0] be; logic [DW-1:0] wdata; } core_req_t;
  typedef struct { int due; logic [AW-1:0] addr; bit we; bit err; } slv_item_t;
  typedef struct { bit we; logic [AW-1:0] addr; } pend_t;

  int n_checks = 0, n_fail = 0, cyc_n = 0;

  // core driver
  core_req_t core_list[$];
  core_req_t cur;
  bit cur_valid = 0, rand_core = 0;
  int req_pct = 0;
  // slave model
  slv_item_t sq[$];
  int lat_min = 0, lat_max = 0, stall_pct = 0, err_pct = 0, spur_pct = 0;
  int stall_force = 0, err_force = 0;
  bit mute = 0, force_ack = 0;
  // reference model: queue of requests still owed an answer, expected response per cycle
  pend_t pend[$];
  int abort_at = -1, last_evt = 0;
  bit cur_rv = 0, cur_err = 0, nxt_rv = 0, nxt_err = 0;
  logic [DW-1:0] cur_rd = '0, nxt_rd = '0;
  // observation logs
  int g_log[$], rv_log[$], drop_log[$];
  bit rverr_log[$];
  logic [DW-1:0] rvdat_log[$];
  int stall_cnt = 0;
  bit prev_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    if (a == 32'h104) return 32'h12345678;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic core_req_t mk_req(input bit w, input logic [AW-1:0] a);
    core_req_t r;
    r.we = w; r.addr = a; r.be = 4'hF; r.wdata = $urandom;
    return r;
  endfunction

  task automatic cfg_slave(input int lmin, input int lmax, input int stp, input int erp, input int spp);
    lat_min = lmin; lat_max = lmax; stall_pct = stp; err_pct = erp; spur_pct = spp;
  endtask

  task automatic clear_logs();
    g_log.delete(); rv_log.delete(); drop_log.delete(); rverr_log.delete(); rvdat_log.delete();
    stall_cnt = 0;
  endtask

  task automatic model_cycle();
    bit dead, exp_stb, exp_gnt, exp_cyc;
    pend_t p;
    dead = 0;
    // After an abort: one abort cycle, then error answers one per cycle until nothing is owed.
    if (abort_at >= 0) begin
      if (cyc_n - abort_at < 2 || pend.size() > 0) dead = 1;
      else abort_at = -1;
    end
    if (!dead && pend.size() > 0 && cyc_n - last_evt >= TO) begin
      abort_at = cyc_n;
      dead = 1;
    end
    exp_stb = !dead && req && (pend.size() < MO);
    exp_gnt = exp_stb && !wb_stall;
    exp_cyc = exp_stb || (!dead && pend.size() > 0);
    check_eq("gnt", 64'(gnt), 64'(exp_gnt));
    check_eq("wb_stb", 64'(wb_stb), 64'(exp_stb));
    check_eq("wb_cyc", 64'(wb_cyc), 64'(exp_cyc));
    if (exp_stb) begin
      check_eq("wb_adr", 64'(wb_adr), 64'(addr));
      check_eq("wb_we", 64'(wb_we), 64'(we));
      check_eq("wb_sel", 64'(wb_sel), 64'(be));
      check_eq("wb_dat_o", 64'(wb_dat_o), 64'(wdata));
    end
    check_eq("rvalid", 64'(rvalid), 64'(cur_rv));
    if (cur_rv) begin
      check_eq("err", 64'(err), 64'(cur_err));
      check_eq("rdata", 64'(rdata), 64'(cur_rd));
    end
    nxt_rv = 0; nxt_err = 0; nxt_rd = '0;
    if (dead) begin
      if (pend.size() > 0) begin
        p = pend.pop_front();
        nxt_rv = 1; nxt_err = 1;
      end
    end else begin
      if ((wb_ack || wb_err) && pend.size() > 0) begin
        p = pend.pop_front();
        nxt_rv = 1;
        nxt_err = wb_err;
        nxt_rd = (!p.we && !wb_err) ? rd_val(p.addr) : '0;
        last_evt = cyc_n;
      end
      if (exp_gnt) begin
        pend.push_back('{we, addr});
        last_evt = cyc_n;
      end
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance at next posedge.
  task automatic tick();
    bit slv_term;
    slv_item_t it;
    if (!cur_valid) begin
      if (core_list.size() > 0) begin
        cur = core_list.pop_front(); cur_valid = 1;
      end else if (rand_core && $urandom_range(99) < req_pct) begin
        cur.we = 1'($urandom_range(1)); cur.addr = $urandom;
        cur.be = 4'($urandom_range(15, 1)); cur.wdata = $urandom;
        cur_valid = 1;
      end
    end
    req = cur_valid; we = cur.we; addr = cur.addr; be = cur.be; wdata = cur.wdata;
    wb_ack = 0; wb_err = 0; wb_dat_i = $urandom; slv_term = 0;
    if (!mute && sq.size() > 0 && sq[0].due <= cyc_n) begin
      slv_term = 1;
      if (sq[0].err) begin
        wb_err = 1; wb_ack = 1'($urandom_range(1));
      end else begin
        wb_ack = 1;
        if (!sq[0].we) wb_dat_i = rd_val(sq[0].addr);
      end
    end else if (force_ack) begin
      wb_ack = 1; force_ack = 0;
    end else if (sq.size() == 0 && $urandom_range(99) < spur_pct) begin
      if ($urandom_range(1) == 1) wb_ack = 1; else wb_err = 1;
    end
    if (stall_force > 0) begin
      wb_stall = 1; stall_force--;
    end else wb_stall = ($urandom_range(99) < stall_pct);
    @(negedge clk);
    model_cycle();
    if (gnt) g_log.push_back(cyc_n);
    if (rvalid) begin
      rv_log.push_back(cyc_n); rverr_log.push_back(err); rvdat_log.push_back(rdata);
    end
    if (wb_stb && !gnt) stall_cnt++;
    if (prev_cyc && !wb_cyc) drop_log.push_back(cyc_n);
    prev_cyc = wb_cyc;
    if (slv_term && sq.size() > 0) it = sq.pop_front();
    if (!wb_cyc) sq.delete();
    else if (wb_stb && !wb_stall) begin
      it.due = cyc_n + 1 + int'($urandom_range(lat_max, lat_min));
      it.addr = wb_adr; it.we = wb_we;
      if (err_force > 0) begin it.err = 1; err_force--; end
      else it.err = ($urandom_range(99) < err_pct);
      sq.push_back(it);
    end
    if (cur_valid && gnt) cur_valid = 0;
    @(posedge clk);
    cur_rv = nxt_rv; cur_err = nxt_err; cur_rd = nxt_rd;
    cyc_n++;
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 0; req = 1; wb_ack = 1; wb_stall = 0;
    sq.delete(); pend.delete(); core_list.delete();
    cur_valid = 0; cur_rv = 0; nxt_rv = 0; abort_at = -1;
    stall_force = 0; force_ack = 0; err_force = 0; prev_cyc = 0;
    repeat (ncyc) begin
      @(negedge clk);
      check_eq("rst_gnt", 64'(gnt), 64'(0));
      check_eq("rst_rvalid", 64'(rvalid), 64'(0));
      check_eq("rst_err", 64'(err), 64'(0));
      check_eq("rst_rdata", 64'(rdata), 64'(0));
      check_eq("rst_wb_cyc", 64'(wb_cyc), 64'(0));
      check_eq("rst_wb_stb", 64'(wb_stb), 64'(0));
      @(posedge clk);
      cyc_n++;
      #1;
    end
    rst_n = 1; req = 0; wb_ack = 0;
  endtask

  function automatic bit is_idle();
    return pend.size() == 0 && !cur_valid && core_list.size() == 0 && sq.size() == 0 &&
           abort_at < 0 && !cur_rv && !nxt_rv;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!is_idle() && n < 80) begin
      tick(); n++;
    end
    check_eq("idle_reached", 64'(is_idle()), 64'(1));
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(3);

    // back-to-back reads, zero-wait slave
    cfg_slave(0, 0, 0, 0, 0); clear_logs();
    core_list.push_back(mk_req(0, 32'h100));
    core_list.push_back(mk_req(0, 32'h104));
    wait_idle();
    check_eq("b2b_gnt_count", 64'(g_log.size()), 64'(2));
    check_eq("b2b_rv_count", 64'(rv_log.size()), 64'(2));
    if (g_log.size() == 2 && rv_log.size() == 2) begin
      check_eq("b2b_gnt_gap", 64'(g_log[1] - g_log[0]), 64'(1));
      check_eq("b2b_lat0", 64'(rv_log[0] - g_log[0]), 64'(2));
      check_eq("b2b_lat1", 64'(rv_log[1] - g_log[1]), 64'(2));
      check_eq("b2b_dat0", 64'(rvdat_log[0]), 64'(32'hDEADBEEF));
      check_eq("b2b_dat1", 64'(rvdat_log[1]), 64'(32'h12345678));
      check_eq("b2b_err", 64'({rverr_log[0], rverr_log[1]}), 64'(0));
    end

    // stall held 3 cycles on a write
    clear_logs(); stall_force = 3;
    core_list.push_back(mk_req(1, 32'h200));
    wait_idle();
    check_eq("stall_cycles", 64'(stall_cnt), 64'(3));
    check_eq("stall_rv_count", 64'(rv_log.size()), 64'(1));
    if (rv_log.size() == 1) check_eq("stall_wr_rdata", 64'(rvdat_log[0]), 64'(0));

    // slow slave, three reads: third grant waits for the first answer
    cfg_slave(5, 5, 0, 0, 0); clear_logs();
    core_list.push_back(mk_req(0, 32'h300));
    core_list.push_back(mk_req(0, 32'h304));
    core_list.push_back(mk_req(0, 32'h308));
    wait_idle();
    check_eq("slow_rv_count", 64'(rv_log.size()), 64'(3));
    if (g_log.size() == 3 && rv_log.size() == 3) begin
      check_eq("slow_third_gnt", 64'(g_log[2]), 64'(rv_log[0]));
      check_eq("slow_order2", 64'(rvdat_log[2]), 64'(rd_val(32'h308)));
    end

    // error on first read, ack on second
    cfg_slave(0, 0, 0, 0, 0); clear_logs(); err_force = 1;
    core_list.push_back(mk_req(0, 32'h400));
    core_list.push_back(mk_req(0, 32'h404));
    wait_idle();
    if (rv_log.size() == 2) begin
      check_eq("errfw_err0", 64'(rverr_log[0]), 64'(1));
      check_eq("errfw_dat0", 64'(rvdat_log[0]), 64'(0));
      check_eq("errfw_err1", 64'(rverr_log[1]), 64'(0));
      check_eq("errfw_dat1", 64'(rvdat_log[1]), 64'(rd_val(32'h404)));
    end else check_eq("errfw_rv_count", 64'(rv_log.size()), 64'(2));

    // watchdog: slave never answers
    clear_logs(); mute = 1;
    core_list.push_back(mk_req(0, 32'h500));
    core_list.push_back(mk_req(0, 32'h504));
    repeat (20) tick();
    check_eq("wd_rv_count", 64'(rv_log.size()), 64'(2));
    if (g_log.size() == 2 && drop_log.size() >= 1 && rv_log.size() == 2) begin
      check_eq("wd_drop_gap", 64'(drop_log[0] - g_log[1]), 64'(TO));
      check_eq("wd_err_k1", 64'(rv_log[0] - drop_log[0]), 64'(1));
      check_eq("wd_err_k2", 64'(rv_log[1] - drop_log[0]), 64'(2));
      check_eq("wd_err_flags", 64'({rverr_log[0], rverr_log[1]}), 64'(2'b11));
    end
    mute = 0; force_ack = 1;
    repeat (3) tick();
    check_eq("late_ack_ignored", 64'(rv_log.size()), 64'(2));
    core_list.push_back(mk_req(0, 32'h508));
    wait_idle();
    check_eq("post_wd_rv_count", 64'(rv_log.size()), 64'(3));
    if (rv_log.size() == 3) begin
      check_eq("post_wd_err", 64'(rverr_log[2]), 64'(0));
      check_eq("post_wd_dat", 64'(rvdat_log[2]), 64'(rd_val(32'h508)));
    end

    // reset with two requests outstanding
    cfg_slave(5, 5, 0, 0, 0);
    core_list.push_back(mk_req(0, 32'h600));
    core_list.push_back(mk_req(0, 32'h604));
    for (int i = 0; i < 10 && pend.size() < 2; i++) tick();
    check_eq("rst_pending", 64'(pend.size()), 64'(2));
    do_reset(2);
    clear_logs();
    repeat (10) tick();
    check_eq("rst_no_rvalid", 64'(rv_log.size()), 64'(0));
    cfg_slave(0, 2, 0, 0, 0);
    core_list.push_back(mk_req(0, 32'h610));
    wait_idle();
    check_eq("rst_after_rv", 64'(rv_log.size()), 64'(1));
    if (rv_log.size() == 1) check_eq("rst_after_dat", 64'(rvdat_log[0]), 64'(rd_val(32'h610)));

    // randomized traffic against the reference model
    cfg_slave(0, 4, 25, 10, 5); rand_core = 1; req_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i % 500 == 0) clear_logs();
    end
    rand_core = 0; spur_pct = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
